// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit WISC pipeline: bubble/stall/flush
// sequencing, load-use detection and EX operand forwarding.
module id_ex_stage #(
  parameter int DW  = 16,
  parameter int AW  = 4,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  input  logic           id_valid,
  input  logic [OPW-1:0] id_opcode,
  input  logic [AW-1:0]  id_rs_addr,
  input  logic [AW-1:0]  id_rt_addr,
  input  logic [AW-1:0]  id_rd_addr,
  input  logic           id_rs_used,
  input  logic           id_rt_used,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [DW-1:0]  id_imm,
  input  logic           id_regwrite,
  input  logic           id_memread,
  input  logic           id_memwrite,
  input  logic           exm_regwrite,
  input  logic [AW-1:0]  exm_rd,
  input  logic [DW-1:0]  exm_result,
  input  logic           mwb_regwrite,
  input  logic [AW-1:0]  mwb_rd,
  input  logic [DW-1:0]  mwb_result,
  output logic           ex_valid,
  output logic [OPW-1:0] ex_opcode,
  output logic [AW-1:0]  ex_rd_addr,
  output logic [DW-1:0]  ex_imm,
  output logic           ex_regwrite,
  output logic           ex_memread,
  output logic           ex_memwrite,
  output logic [DW-1:0]  ex_rs,
  output logic [DW-1:0]  ex_rt,
  output logic           hazard_stall
);

  logic           valid_r;
  logic [OPW-1:0] opcode_r;
  logic [AW-1:0]  rs_addr_r;
  logic [AW-1:0]  rt_addr_r;
  logic [AW-1:0]  rd_addr_r;
  logic [DW-1:0]  rs_data_r;
  logic [DW-1:0]  rt_data_r;
  logic [DW-1:0]  imm_r;
  logic           regwrite_r;
  logic           memread_r;
  logic           memwrite_r;

  logic           rs_hit_s;
  logic           rt_hit_s;
  logic           hazard_s;

  // Newest producer wins: EX/MEM before MEM/WB; R0 always reads as the register file value.
  function automatic logic [DW-1:0] fwd_sel(
    input logic [AW-1:0] addr,
    input logic [DW-1:0] reg_data,
    input logic          exm_we,
    input logic [AW-1:0] exm_addr,
    input logic [DW-1:0] exm_data,
    input logic          mwb_we,
    input logic [AW-1:0] mwb_addr,
    input logic [DW-1:0] mwb_data
  );
    logic [DW-1:0] sel;
    if (exm_we && (exm_addr != {AW{1'b0}}) && (exm_addr == addr)) begin
      sel = exm_data;
    end else if (mwb_we && (mwb_addr != {AW{1'b0}}) && (mwb_addr == addr)) begin
      sel = mwb_data;
    end else begin
      sel = reg_data;
    end
    return sel;
  endfunction

  // Load-use detection against the instruction currently in EX.
  always_comb begin
    rs_hit_s = id_rs_used && (id_rs_addr == rd_addr_r);
    rt_hit_s = id_rt_used && (id_rt_addr == rd_addr_r);
    hazard_s = valid_r && memread_r && id_valid &&
               (rd_addr_r != {AW{1'b0}}) && (rs_hit_s || rt_hit_s);
  end

  // Stage register: reset > flush > stall > load-use bubble > load.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && hazard_s)) begin
      valid_r    <= 1'b0;
      opcode_r   <= {OPW{1'b0}};
      rs_addr_r  <= {AW{1'b0}};
      rt_addr_r  <= {AW{1'b0}};
      rd_addr_r  <= {AW{1'b0}};
      rs_data_r  <= {DW{1'b0}};
      rt_data_r  <= {DW{1'b0}};
      imm_r      <= {DW{1'b0}};
      regwrite_r <= 1'b0;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
    end else if (stall) begin
      valid_r    <= valid_r;
      opcode_r   <= opcode_r;
      rs_addr_r  <= rs_addr_r;
      rt_addr_r  <= rt_addr_r;
      rd_addr_r  <= rd_addr_r;
      rs_data_r  <= rs_data_r;
      rt_data_r  <= rt_data_r;
      imm_r      <= imm_r;
      regwrite_r <= regwrite_r;
      memread_r  <= memread_r;
      memwrite_r <= memwrite_r;
    end else begin
      valid_r    <= id_valid;
      opcode_r   <= id_opcode;
      rs_addr_r  <= id_rs_addr;
      rt_addr_r  <= id_rt_addr;
      rd_addr_r  <= id_rd_addr;
      rs_data_r  <= id_rs_data;
      rt_data_r  <= id_rt_data;
      imm_r      <= id_imm;
      regwrite_r <= id_regwrite && id_valid;
      memread_r  <= id_memread && id_valid;
      memwrite_r <= id_memwrite && id_valid;
    end
  end

  // Output drive: registered fields plus live forwarding on the held addresses.
  always_comb begin
    ex_valid     = valid_r;
    ex_opcode    = opcode_r;
    ex_rd_addr   = rd_addr_r;
    ex_imm       = imm_r;
    ex_regwrite  = regwrite_r;
    ex_memread   = memread_r;
    ex_memwrite  = memwrite_r;
    hazard_stall = hazard_s;
    ex_rs = fwd_sel(rs_addr_r, rs_data_r, exm_regwrite, exm_rd, exm_result,
                    mwb_regwrite, mwb_rd, mwb_result);
    ex_rt = fwd_sel(rt_addr_r, rt_data_r, exm_regwrite, exm_rd, exm_result,
                    mwb_regwrite, mwb_rd, mwb_result);
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 16-bit WISC pipeline; sits directly upstream of the EX-stage ALU/RED unit and supplies its rs/rt operands.
- Registers decoded operands and controls on each clock and applies stall, flush and load-use bubble insertion.
- Drives forwarded EX operands, resolved from the EX/MEM and MEM/WB result buses.

Parameters:
- DW, 16, datapath width.
- AW, 4, register address width; R0 is hardwired zero.
- OPW, 4, opcode width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  external freeze; hold all stage state
- flush  in  1  branch/redirect; kill the instruction entering EX
- id_valid  in  1  decode holds a real instruction
- id_opcode  in  OPW  decoded opcode
- id_rs_addr, id_rt_addr, id_rd_addr  in  AW  source/dest register numbers
- id_rs_used, id_rt_used  in  1  instruction actually reads rs/rt
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_regwrite, id_memread, id_memwrite  in  1  controls
- exm_regwrite  in  1;  exm_rd  in  AW;  exm_result  in  DW  (EX/MEM bus)
- mwb_regwrite  in  1;  mwb_rd  in  AW;  mwb_result  in  DW  (MEM/WB bus)
- ex_valid  out  1  registered valid
- ex_opcode  out  OPW;  ex_rd_addr  out  AW;  ex_imm  out  DW
- ex_regwrite, ex_memread, ex_memwrite  out  1  registered controls, gated by valid
- ex_rs, ex_rt  out  DW  forwarded operands to ALU/RED
- hazard_stall  out  1  load-use detected; IF/ID must hold

Behaviour:
- Reset: on rising edge with rst=1, every registered field clears to 0. Resulting outputs are ex_valid=0, all controls 0, ex_opcode=0, ex_rd_addr=0 and ex_imm=0.
- With all registered fields 0 and exm_regwrite = mwb_regwrite = 0, ex_rs = ex_rt = 0 and hazard_stall = 0.
- hazard_stall is combinational, asserted when all of the following hold:
  - ex_valid, ex_memread and id_valid are all 1.
  - ex_rd_addr != 0.
  - Either (id_rs_used and id_rs_addr == ex_rd_addr) or (id_rt_used and id_rt_addr == ex_rd_addr).
- Update priority per edge:
  1. rst: clear.
  2. flush: load bubble.
  3. stall: hold all fields unchanged.
  4. hazard_stall: load bubble.
  5. Otherwise: load all id_* fields.
- Bubble definition: ex_valid=0 and regwrite/memread/memwrite=0; other fields are don't-care but are cleared to 0.
- Flush overrides stall. Stall overrides hazard, so the bubble is inserted on the first non-stalled edge.
- Latency: id_* inputs appear on ex_* one cycle after a load edge.
- Controls are stored as id_X & id_valid, so an invalid instruction never writes.
- Forwarding (combinational, from registered rs/rt addresses), per operand:
  - If exm_regwrite, exm_rd != 0 and exm_rd == the operand's address: select exm_result.
  - Else, if mwb_regwrite, mwb_rd != 0 and mwb_rd == the operand's address: select mwb_result.
  - Else: select the registered data.
  - EX/MEM has priority over MEM/WB.
- R0: address 0 is never forwarded and never triggers a hazard.
- While stall=1, forwarding remains live on the held fields.
- A load-use pair resolves in exactly one bubble: the next edge moves the load to MEM, and its data then returns via MEM/WB forwarding.
- Reset mid-operation: a pending hazard is dropped and hazard_stall deasserts the cycle after reset.

Test Plan:
- Basic load:
  - Stimulus: id_valid=1, opcode=4'h3, rs=2, rs_data=16'h0101, rt=3, rt_data=16'h1234, rd=4, regwrite=1, no forwarding.
  - Response: after 1 edge, ex_valid=1, ex_rs=16'h0101, ex_rt=16'h1234, ex_rd_addr=4, ex_regwrite=1.
- Forward priority:
  - Stimulus: EX holds rs=5. exm_regwrite=1, exm_rd=5, exm_result=16'hFFFF; mwb_regwrite=1, mwb_rd=5, mwb_result=16'h00FE.
  - Response: ex_rs=16'hFFFF. Dropping exm_regwrite gives ex_rs=16'h00FE.
- R0 guard:
  - Stimulus: rs=0, exm_regwrite=1, exm_rd=0, exm_result=16'hE300.
  - Response: ex_rs = registered data (16'h0000).
- Load-use:
  - Stimulus: EX holds memread=1, rd=6. Decode has rt=6, rt_used=1.
  - Response: hazard_stall=1. Next edge gives ex_valid=0, ex_regwrite=0, and the held instruction loads on the following edge with hazard_stall=0.
- Stall vs flush:
  - Stimulus: stall=1 for 3 cycles with changing id_* inputs.
  - Response: ex_* unchanged. stall=1 and flush=1 together give ex_valid=0 on the next edge.
- Reset:
  - Stimulus: valid instruction in EX, rst=1 for one edge.
  - Response: ex_valid=0, all controls 0, ex_imm=0, and hazard_stall=0 the following cycle.
